// File: rtl/trig_arb_pkg.sv
// rtl/trig_arb_pkg.sv - shared state enum, register offsets and channel width for trig_fifo_arb
package trig_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam logic [15:0] REG_CTRL = 16'd0;
   localparam logic [15:0] REG_STAT = 16'd1;
   localparam logic [15:0] REG_CNT0 = 16'd2;

   localparam int CH_W = 2;

endpackage

// File: rtl/trig_fifo_arb_bregs.sv
// rtl/trig_fifo_arb_bregs.sv - bus register cells: bregpl (read/write) and brorpl (read-only)
module bregpl #(
   parameter logic [15:0]  ADDR = 16'h0000,
   parameter int           W    = 16,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_i,
   input  logic [15:0]  addr_i,
   input  logic [W-1:0] wdata_i,
   input  logic         hold_i,
   output logic [W-1:0] q_o,
   output logic         hit_o,
   output logic [15:0]  rdata_o
);

   logic [W-1:0] q_q;

   assign hit_o   = (addr_i == ADDR);
   assign q_o     = q_q;
   assign rdata_o = hit_o ? 16'(q_q) : 16'h0000;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= INIT;
      end else if (wr_i && hit_o && !hold_i) begin
         q_q <= wdata_i;
      end
   end

endmodule

module brorpl #(
   parameter logic [15:0] ADDR = 16'h0000
) (
   input  logic [15:0] addr_i,
   input  logic [15:0] d_i,
   output logic        hit_o,
   output logic [15:0] rdata_o
);

   assign hit_o   = (addr_i == ADDR);
   assign rdata_o = hit_o ? d_i : 16'h0000;

endmodule

// File: rtl/trig_fifo_arb_rr_pick4.sv
// rtl/trig_fifo_arb_rr_pick4.sv - combinational 4-way round-robin picker starting after the last grant
module rr_pick4
   import trig_arb_pkg::*;
(
   input  logic [3:0]      mask_i,
   input  logic [CH_W-1:0] last_i,
   output logic            any_o,
   output logic [CH_W-1:0] pick_o
);

   logic [CH_W-1:0] idx;

   // Walk from the farthest offset down so the nearest requester after last_i wins.
   always_comb begin
      any_o  = 1'b0;
      pick_o = last_i;
      idx    = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last_i + CH_W'(k);
         if (mask_i[idx]) begin
            any_o  = 1'b1;
            pick_o = idx;
         end
      end
   end

endmodule

// File: rtl/trig_fifo_arb.sv
// rtl/trig_fifo_arb.sv - 4-requester burst round-robin arbiter into a FIFO; TRIG_FIFO_ARB_STATS_EN adds per-channel counters
module trig_fifo_arb
   import trig_arb_pkg::*;
#(
   parameter logic [15:0] MYADDR    = 16'h0040,
   parameter int          BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [33:0] ibus,
   output logic [15:0] obus,
   input  logic [3:0]  req_valid,
   input  logic [63:0] req_data,
   output logic [3:0]  req_ready,
   output logic [17:0] fifo_d,
   output logic        fifo_wen,
   input  logic        fifo_nearlyfull
);

   logic            bus_wr;
   logic [15:0]     bus_addr;
   logic [15:0]     bus_wdata;
   logic [11:0]     bus_unused;
   logic            soft_clr;

   logic [3:0]      enable;
   logic            ctrl_hit;
   logic [15:0]     ctrl_rd;
   logic            stat_hit;
   logic [15:0]     stat_rd;
   logic            rd_any;
   logic [15:0]     rd_or;

   arb_state_t      state_q;
   logic [CH_W-1:0] last_q;
   logic [3:0]      burst_q;
   logic            fifo_wen_q;
   logic [17:0]     fifo_d_q;

   logic [3:0]      cand;
   logic            pick_any;
   logic [CH_W-1:0] pick_ch;
   logic            grant_ok;
   logic            xfer;
   logic [15:0]     sel_data;
   logic [3:0]      burst_d;
   logic            burst_done;

   assign bus_wr     = ibus[32];
   assign bus_addr   = ibus[31:16];
   assign bus_wdata  = ibus[15:0];
   assign bus_unused = {ibus[33], ibus[15:5]};
   assign soft_clr   = bus_wr && (bus_addr == MYADDR + REG_CTRL) && bus_wdata[4];

   // A soft-clear write leaves the enable mask untouched.
   bregpl #(
      .ADDR (MYADDR + REG_CTRL),
      .W    (4),
      .INIT (4'hF)
   ) u_ctrl (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_i    (bus_wr),
      .addr_i  (bus_addr),
      .wdata_i (bus_wdata[3:0]),
      .hold_i  (bus_wdata[4]),
      .q_o     (enable),
      .hit_o   (ctrl_hit),
      .rdata_o (ctrl_rd)
   );

   brorpl #(
      .ADDR (MYADDR + REG_STAT)
   ) u_stat (
      .addr_i  (bus_addr),
      .d_i     ({5'b0, req_valid, burst_q, last_q, state_q == GRANT}),
      .hit_o   (stat_hit),
      .rdata_o (stat_rd)
   );

   assign cand = req_valid & enable;

   rr_pick4 u_pick (
      .mask_i (cand),
      .last_i (last_q),
      .any_o  (pick_any),
      .pick_o (pick_ch)
   );

   assign grant_ok   = (state_q == GRANT) && cand[last_q];
   assign xfer       = grant_ok && !fifo_nearlyfull;
   assign sel_data   = req_data[{last_q, 4'b0000} +: 16];
   assign burst_d    = burst_q + 4'd1;
   assign burst_done = (burst_d == 4'(BURST_MAX));

   always_comb begin
      req_ready = 4'b0000;
      if ((state_q == GRANT) && enable[last_q] && !fifo_nearlyfull) begin
         req_ready[last_q] = 1'b1;
      end
   end

   // last_q doubles as the current grant channel while in GRANT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_q     <= 2'd3;
         burst_q    <= 4'd0;
         fifo_wen_q <= 1'b0;
         fifo_d_q   <= 18'h0;
      end else begin
         fifo_wen_q <= xfer;
         if (xfer) begin
            fifo_d_q <= {last_q, sel_data};
         end
         if (soft_clr) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            burst_q <= 4'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (pick_any) begin
                     state_q <= GRANT;
                     last_q  <= pick_ch;
                     burst_q <= 4'd0;
                  end
               end
               GRANT: begin
                  if (!grant_ok) begin
                     state_q <= IDLE;
                  end else if (xfer) begin
                     burst_q <= burst_d;
                     if (burst_done) begin
                        state_q <= IDLE;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign fifo_wen = fifo_wen_q;
   assign fifo_d   = fifo_d_q;

`ifdef TRIG_FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [4];
   logic [3:0]  cnt_hit;
   logic [15:0] cnt_rd [4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 16'h0;
      end else if (soft_clr) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 16'h0;
      end else if (xfer) begin
         cnt_q[last_q] <= cnt_q[last_q] + 16'd1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      brorpl #(
         .ADDR (MYADDR + REG_CNT0 + 16'(g))
      ) u_cnt (
         .addr_i  (bus_addr),
         .d_i     (cnt_q[g]),
         .hit_o   (cnt_hit[g]),
         .rdata_o (cnt_rd[g])
      );
   end

   assign rd_any = ctrl_hit | stat_hit | (|cnt_hit);
   assign rd_or  = ctrl_rd | stat_rd | cnt_rd[0] | cnt_rd[1] | cnt_rd[2] | cnt_rd[3];
`else
   assign rd_any = ctrl_hit | stat_hit;
   assign rd_or  = ctrl_rd | stat_rd;
`endif

   assign obus = rd_any ? rd_or : 16'bz;

endmodule

// File: doc/trig_fifo_arb.md
TRIG_FIFO_ARB -- requirements
Module: trig_fifo_arb

Interface
REQ-001: Parameter MYADDR, default 16'h0040, base register-bus address of the block's registers.
REQ-002: Parameter BURST_MAX, default 4, maximum words granted to one requester per arbitration (1..15).
REQ-003: Port clk input 1, single clock for all logic.
REQ-004: Port reset_n input 1, reset, asynchronous assertion, active-low.
REQ-005: Port ibus input 34, register bus {clk, wr, addr[15:0], wrdata[15:0]}.
REQ-006: Port obus output 16, register read data, driven only when addr matches an owned address, else 16'bz.
REQ-007: Port req_valid input 4, per-requester word available.
REQ-008: Port req_data input 64, four 16-bit words, requester i at bits [16i+15:16i].
REQ-009: Port req_ready output 4, per-requester word accepted this cycle.
REQ-010: Port fifo_d output 18, FIFO write word {channel[1:0], data[15:0]}.
REQ-011: Port fifo_wen output 1, FIFO write strobe.
REQ-012: Port fifo_nearlyfull input 1, FIFO backpressure.

Function
REQ-013: A transfer on requester i occurs in any cycle with req_valid[i] and req_ready[i] both high.
REQ-014: req_ready is combinational; at most one bit is high; bit i is high only in state GRANT, with grant channel = i, enable[i] = 1, and fifo_nearlyfull = 0.
REQ-015: fifo_wen and fifo_d are registered; a transfer in cycle N gives fifo_wen = 1 and fifo_d = {i, data} in cycle N+1; otherwise fifo_wen = 0 and fifo_d holds its value.
REQ-016: States: IDLE, GRANT.
REQ-017: IDLE -> GRANT when any requester has req_valid = 1 and enable = 1; the grant goes to the first such channel after last_grant, searched in the order last_grant+1, +2, +3, +4 (mod 4).
REQ-018: On entry to GRANT, last_grant takes the granted channel and the burst counter clears.
REQ-019: Each transfer increments the burst counter.
REQ-020: GRANT -> IDLE after the transfer that makes the burst count equal BURST_MAX.
REQ-021: GRANT -> IDLE in any cycle in which the granted channel has req_valid = 0 or enable = 0; no transfer occurs in that cycle.
REQ-022: fifo_nearlyfull = 1 in GRANT stalls without leaving GRANT and without incrementing the burst counter.
REQ-023: IDLE always lasts at least one cycle between grants, so peak throughput is BURST_MAX words per BURST_MAX+1 cycles.
REQ-024: Register MYADDR (R/W): bits[3:0] enable mask, power-up 4'hF; bit[4] write-1 soft clear, self-clearing, reads 0.
REQ-025: Register MYADDR+1 (RO): bit[0] state (1 = GRANT), bits[2:1] last_grant, bits[6:3] burst count, bits[10:7] req_valid.
REQ-026: Soft clear forces IDLE, last_grant = 3 and burst count = 0 on the next clock; the enable mask keeps its value.
REQ-027: A register write clearing enable[i] during an active grant on i ends the grant per REQ-021 in the cycle after the write.

Reset
REQ-028: While reset_n = 0: state IDLE, last_grant 3 (channel 0 wins first), burst 0, fifo_wen 0, fifo_d 0, enable 4'hF, statistics counters 0.
REQ-029: Reset in the middle of a burst drops the outstanding registered write, so fifo_wen is 0 in the first cycle after release.

Configuration
REQ-030: With TRIG_FIFO_ARB_STATS_EN defined, registers MYADDR+2..MYADDR+5 (RO) hold 16-bit per-channel transfer counters that wrap 16'hFFFF -> 0 and are cleared by reset and soft clear.
REQ-031: Without TRIG_FIFO_ARB_STATS_EN, the counters are absent, addresses MYADDR+2..+5 are not decoded, and obus stays 16'bz at those addresses.

Structure
REQ-032: Shared package trig_arb_pkg holds the state enum (IDLE = 0, GRANT = 1), the register offsets (CTRL = 0, STAT = 1, CNT0 = 2) and the channel-width constant 2.
REQ-033: One sub-module, rr_pick4, is combinational and maps (request mask[3:0], last[1:0]) to (any, pick[1:0]).
REQ-034: Bus registers use the team's bregpl and brorpl register cells.

Verification
REQ-035: Only requester 2 valid, data 16'hA5A5, for 4 words -> 4 writes of 18'h2A5A5, fifo_wen one cycle after each req_ready, then IDLE.
REQ-036: All four requesters continuously valid, BURST_MAX = 4 -> channel order 0,1,2,3,0, 4 words each, one idle cycle between bursts.
REQ-037: fifo_nearlyfull held high for 3 cycles mid-burst -> req_ready = 0 for those 3 cycles, burst still totals 4 words, no words lost or duplicated.
REQ-038: Write 16'h000E to MYADDR while channel 0 is granted -> channel 0 is released next cycle, channel 0 receives no further req_ready, and the next grant goes to channel 1.
REQ-039: Assert reset_n = 0 in the middle of a burst -> after release: fifo_wen = 0, STAT reads 16'h0006 with all req_valid low, and the first grant goes to channel 0.
REQ-040: With TRIG_FIFO_ARB_STATS_EN, 70000 transfers on channel 1 -> MYADDR+3 reads 16'h1170 (70000 mod 65536 = 4464); without the macro, MYADDR+3 reads 16'bz.
